db_scan_ctrl: RTL and testbench
===============================

Name: db_scan_ctrl

Overview:
- Multi-channel debounce controller: one shared sample-tick prescaler, N per-channel debounce FSMs, and a round-robin arbiter.
- The arbiter serialises debounced edge events onto one valid/ready event port.
- Sits between raw switch/button pads and the system event consumer. Replaces N free-running debouncers with one scheduled resource.

Parameters:
N_CH, 4, number of switch channels (2..16)
SAMPLE_DIV, 1000, clk_i cycles per sample tick (>=2)
STABLE_SAMPLES, 8, consecutive equal samples needed to accept a level change (2..255)

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset, asynchronous, active-low
en_i  input  1  enable sampling; 0 freezes prescaler and channel FSMs
sw_i  input  N_CH  raw asynchronous switch inputs
level_o  output  N_CH  debounced level per channel
pend_o  output  N_CH  event pending (not yet loaded to output) per channel
evt_valid_o  output  1  event available
evt_ready_i  input  1  consumer accepts event
evt_ch_o  output  $clog2(N_CH)  channel of current event
evt_rise_o  output  1  1 = rising (press), 0 = falling (release)
ovf_o  output  1  sticky: event overwritten while still pending
ovf_clr_i  input  1  synchronous clear of ovf_o

Behaviour:
- Reset (rst_i=0, async): all outputs 0, prescaler 0, synchronisers 0, all FSMs ZERO, arbiter pointer "last granted" = N_CH-1.
- Synchroniser: 2-flop per channel. sync[ch] lags sw_i by 2 cycles.
- Prescaler:
  - Counts 0..SAMPLE_DIV-1 while en_i=1.
  - sample_tick is a 1-cycle pulse when count==SAMPLE_DIV-1; count then wraps to 0.
  - en_i=0 forces count to 0 and produces no ticks. FSM states/counters hold; pending events are still arbitrated.
- Channel FSM: updates only on sample_tick; cnt is 8 bits.
  - ZERO: sync=1 -> WAIT1, cnt=1.
  - WAIT1: sync=0 -> ZERO. sync=1 and cnt+1==STABLE_SAMPLES -> ONE, raise rise event. Otherwise cnt++.
  - ONE: sync=0 -> WAIT0, cnt=1.
  - WAIT0: sync=1 -> ONE (no event). sync=0 and cnt+1==STABLE_SAMPLES -> ZERO, raise fall event. Otherwise cnt++.
  - level_o[ch]=1 in ONE and WAIT0, registered.
  - Acceptance: the STABLE_SAMPLES-th consecutive equal sample.
- Event capture:
  - An event sets pend[ch]=1 and dir[ch] in the same edge as the FSM transition.
  - If pend[ch] is already 1 and not being loaded that cycle: dir is overwritten and ovf_o is set.
  - ovf_clr_i=1 clears ovf_o. A set in the same cycle wins.
- Arbiter/output register:
  - Output slot is free when evt_valid_o=0 or (evt_valid_o & evt_ready_i).
  - When free and any pend=1: grant the first pending channel scanning upward from last+1 with wrap. Load evt_ch_o/evt_rise_o, set evt_valid_o, clear that pend bit, update last.
  - Latency: pend set at edge k -> evt_valid_o at edge k+1 if slot free.
  - Back-to-back: accept and load in the same cycle keep evt_valid_o high, giving 1 event/cycle.
  - While evt_valid_o & !evt_ready_i: evt_ch_o and evt_rise_o are stable.
  - Slot free, nothing pending -> evt_valid_o=0.
  - New event for the channel being loaded in the same cycle: pend stays 1 with the new dir, no overflow.
- Reset mid-operation: immediate return to reset state. In-flight events are dropped; no event is generated for a level already held at reset release until it is debounced from ZERO.

Test Plan:
(N_CH=4, SAMPLE_DIV=4, STABLE_SAMPLES=3, evt_ready_i=1, en_i=1 unless stated)
- Reset: rst_i=0 with sw_i=4'hF -> all outputs 0. After release, channels debounce up: four rise events in order ch0,1,2,3 on consecutive cycles.
- Clean press: sw_i[2] 0->1 held -> level_o[2]=1 and one event {ch=2, rise=1} within 2+3*4+2 cycles. Release held -> {ch=2, rise=0}.
- Bounce: sw_i[1] toggles every 5 cycles for 200 cycles, then returns to 0 -> no event, level_o[1]=0 throughout.
- Simultaneous/back-to-back: sw_i[0] and sw_i[3] rise in the same cycle -> events ch0 then ch3 on consecutive cycles, evt_valid_o high for 2 cycles.
- Backpressure/overflow: evt_ready_i=0; ch1 press -> evt held {1,1}. Then ch1 release -> pend_o[1]=1. Then ch1 press -> ovf_o=1. Then evt_ready_i=1 -> {1,1}, {1,1}. ovf_clr_i pulse -> ovf_o=0.
- Freeze and reset mid-operation: en_i=0 while ch2 is in WAIT1 -> no tick, level_o[2] unchanged for 100 cycles. Assert rst_i during evt_valid_o=1 -> evt_valid_o=0 asynchronously, pend_o=0.

Source files
------------

// File: rtl/db_scan_ctrl.sv
// Multi-channel switch debounce controller.
// A shared prescaler produces sample ticks. Each channel has a debounce FSM.
// A round-robin arbiter serialises the debounced edge events onto a single
// valid/ready event port, with a sticky flag for overwritten events.

// One debounce channel: accepts a level change on the STABLE_SAMPLES-th
// consecutive equal sample and reports the accepting tick as an event.
module db_chan #(
    parameter int STABLE_SAMPLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic smp,
    output logic level,
    output logic evt,
    output logic rise
);
    typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} st_t;

    st_t        st;
    logic [7:0] cnt;
    logic       done;

    assign done = (cnt + 8'd1) == 8'(STABLE_SAMPLES);
    // The event fires in the same cycle as the accepting transition, so the
    // capture logic in the parent can latch it on that same edge.
    assign evt  = tick && done && ((st == WAIT1 && smp) || (st == WAIT0 && !smp));
    assign rise = (st == WAIT1);

    // Debounce state machine, advanced only on sample ticks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= ZERO;
            cnt   <= 8'd0;
            level <= 1'b0;
        end else if (tick) begin
            case (st)
                ZERO: if (smp) begin
                    st  <= WAIT1;
                    cnt <= 8'd1;
                end
                WAIT1: begin
                    if (!smp) st <= ZERO;
                    else if (done) begin
                        st    <= ONE;
                        level <= 1'b1;
                    end else cnt <= cnt + 8'd1;
                end
                ONE: if (!smp) begin
                    st  <= WAIT0;
                    cnt <= 8'd1;
                end
                WAIT0: begin
                    if (smp) st <= ONE;
                    else if (done) begin
                        st    <= ZERO;
                        level <= 1'b0;
                    end else cnt <= cnt + 8'd1;
                end
                default: st <= ZERO;
            endcase
        end
    end
endmodule

module db_scan_ctrl #(
    parameter int N_CH           = 4,
    parameter int SAMPLE_DIV     = 1000,
    parameter int STABLE_SAMPLES = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic [N_CH-1:0]         sw_i,
    output logic [N_CH-1:0]         level_o,
    output logic [N_CH-1:0]         pend_o,
    output logic                    evt_valid_o,
    input  logic                    evt_ready_i,
    output logic [$clog2(N_CH)-1:0] evt_ch_o,
    output logic                    evt_rise_o,
    output logic                    ovf_o,
    input  logic                    ovf_clr_i
);
    localparam int CW = $clog2(N_CH);
    localparam int PW = $clog2(SAMPLE_DIV);

    logic [N_CH-1:0] sync1, sync2;
    logic [PW-1:0]   pcnt;
    logic            tick;
    logic [N_CH-1:0] ev, ev_rise;
    logic [N_CH-1:0] pend, dir;
    logic [CW-1:0]   last;
    logic [CW-1:0]   gnt_ch;
    logic            gnt_any;
    logic            free, load;
    logic [N_CH-1:0] clr_vec;
    logic            ovf_set;
    int unsigned     idx;

    // Two-flop synchroniser for the raw pad inputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_i;
            sync2 <= sync1;
        end
    end

    assign tick = en_i && (pcnt == PW'(SAMPLE_DIV - 1));

    // Sample prescaler; disabling clears it so the next tick is a full period away
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)      pcnt <= '0;
        else if (!en_i)  pcnt <= '0;
        else if (tick)   pcnt <= '0;
        else             pcnt <= pcnt + PW'(1);
    end

    db_chan #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_chan [N_CH-1:0] (
        .clk   (clk_i),
        .rst_n (rst_i),
        .tick  (tick),
        .smp   (sync2),
        .level (level_o),
        .evt   (ev),
        .rise  (ev_rise)
    );

    // Round-robin pick: first pending channel after the last granted one
    always_comb begin
        gnt_any = 1'b0;
        gnt_ch  = '0;
        idx     = 0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(last) + k) % N_CH;
            if (!gnt_any && pend[idx]) begin
                gnt_any = 1'b1;
                gnt_ch  = CW'(idx);
            end
        end
    end

    assign free    = !evt_valid_o || evt_ready_i;
    assign load    = free && gnt_any;
    assign clr_vec = load ? (N_CH'(1) << gnt_ch) : '0;
    // Only an event landing on a pending bit that is not leaving this cycle is lost
    assign ovf_set = |(ev & pend & ~clr_vec);

    // Output slot: reload whenever empty or being consumed
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            evt_valid_o <= 1'b0;
            evt_ch_o    <= '0;
            evt_rise_o  <= 1'b0;
            last        <= CW'(N_CH - 1);
        end else if (free) begin
            evt_valid_o <= gnt_any;
            if (gnt_any) begin
                evt_ch_o   <= gnt_ch;
                evt_rise_o <= dir[gnt_ch];
                last       <= gnt_ch;
            end
        end
    end

    // Pending events; a fresh event wins over the grant clearing its bit
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pend <= '0;
            dir  <= '0;
        end else begin
            pend <= (pend & ~clr_vec) | ev;
            dir  <= (dir & ~ev) | (ev & ev_rise);
        end
    end

    // Sticky overflow flag; a new overflow beats a clear in the same cycle
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)          ovf_o <= 1'b0;
        else if (ovf_set)    ovf_o <= 1'b1;
        else if (ovf_clr_i)  ovf_o <= 1'b0;
    end

    assign pend_o = pend;
endmodule

// File: tb/tb_db_scan_ctrl.sv
// Bench for db_scan_ctrl: directed scenarios plus random switch traffic,
// compared every cycle against a behavioural model of the debounce rules.
module tb_db_scan_ctrl;
    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int ST  = 3;

    logic         clk_i = 1'b0;
    logic         rst_i, en_i, evt_ready_i, ovf_clr_i;
    logic [N-1:0] sw_i, level_o, pend_o;
    logic         evt_valid_o, evt_rise_o, ovf_o;
    logic [1:0]   evt_ch_o;

    db_scan_ctrl #(.N_CH(N), .SAMPLE_DIV(DIV), .STABLE_SAMPLES(ST)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .sw_i(sw_i),
        .level_o(level_o), .pend_o(pend_o), .evt_valid_o(evt_valid_o),
        .evt_ready_i(evt_ready_i), .evt_ch_o(evt_ch_o), .evt_rise_o(evt_rise_o),
        .ovf_o(ovf_o), .ovf_clr_i(ovf_clr_i)
    );

    always #5 clk_i = ~clk_i;

    int passes = 0;
    int total  = 0;
    int cyc    = 0;

    // Behavioural model: level, run length of samples differing from it,
    // pending flag/direction per channel, and the output slot.
    int ms1[N], ms2[N], mlvl[N], mrun[N], mpend[N], mdir[N];
    int mpc, mov, mv, mch, mrise, mlast;

    // Accepted-event log taken from the port
    int lch[$], lr[$], lcyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passes = passes + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            ms1[c] = 0; ms2[c] = 0; mlvl[c] = 0; mrun[c] = 0; mpend[c] = 0; mdir[c] = 0;
        end
        mpc = 0; mov = 0; mv = 0; mch = 0; mrise = 0; mlast = N - 1;
    endtask

    task automatic model_update();
        int tick, free, gch, ovs;
        int ev[N];
        tick = (en_i && mpc == DIV - 1) ? 1 : 0;
        mpc  = (!en_i || tick != 0) ? 0 : mpc + 1;
        for (int c = 0; c < N; c++) begin
            ev[c] = 0;
            if (tick != 0) begin
                if (ms2[c] != mlvl[c]) begin
                    mrun[c]++;
                    if (mrun[c] == ST) begin
                        mlvl[c] = ms2[c];
                        mrun[c] = 0;
                        ev[c]   = 1;
                    end
                end else mrun[c] = 0;
            end
            ms2[c] = ms1[c];
            ms1[c] = int'(sw_i[c]);
        end
        free = (!mv || evt_ready_i) ? 1 : 0;
        gch  = -1;
        if (free != 0)
            for (int k = 1; k <= N; k++)
                if (gch < 0 && mpend[(mlast + k) % N] != 0) gch = (mlast + k) % N;
        ovs = 0;
        for (int c = 0; c < N; c++)
            if (ev[c] != 0 && mpend[c] != 0 && c != gch) ovs = 1;
        if (free != 0) begin
            if (gch >= 0) begin
                mv = 1; mch = gch; mrise = mdir[gch]; mlast = gch; mpend[gch] = 0;
            end else mv = 0;
        end
        for (int c = 0; c < N; c++)
            if (ev[c] != 0) begin
                mpend[c] = 1;
                mdir[c]  = mlvl[c];
            end
        if (ovs != 0) mov = 1;
        else if (ovf_clr_i) mov = 0;
    endtask

    task automatic check_all();
        logic [N-1:0] lv, pv;
        for (int c = 0; c < N; c++) begin
            lv[c] = (mlvl[c] != 0);
            pv[c] = (mpend[c] != 0);
        end
        chk("level", level_o, lv);
        chk("pend", pend_o, pv);
        chk("valid", evt_valid_o, mv);
        chk("ovf", ovf_o, mov);
        if (mv != 0) begin
            chk("evt_ch", evt_ch_o, mch);
            chk("evt_rise", evt_rise_o, mrise);
        end
    endtask

    // One clock: log handshakes, advance model, check after the edge
    task automatic step();
        if (rst_i && evt_valid_o && evt_ready_i) begin
            lch.push_back(int'(evt_ch_o));
            lr.push_back(int'(evt_rise_o));
            lcyc.push_back(cyc);
        end
        @(posedge clk_i);
        cyc++;
        if (rst_i) model_update();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_log();
        lch.delete(); lr.delete(); lcyc.delete();
    endtask

    initial begin
        int seen;
        model_reset();
        rst_i = 1'b0; en_i = 1'b1; evt_ready_i = 1'b1; ovf_clr_i = 1'b0; sw_i = 4'hF;

        // Reset with all switches high
        run(3);
        chk("rst_level", level_o, 0);
        chk("rst_pend", pend_o, 0);
        chk("rst_valid", evt_valid_o, 0);
        chk("rst_ovf", ovf_o, 0);
        rst_i = 1'b1;
        for (int n = 0; n < 40 && lch.size() < 4; n++) step();
        chk("rst_evcnt", lch.size(), 4);
        if (lch.size() >= 4)
            for (int i = 0; i < 4; i++) begin
                chk("rst_evch", lch[i], i);
                chk("rst_evrise", lr[i], 1);
                chk("rst_evgap", lcyc[i] - lcyc[0], i);
            end

        // Release all, then simultaneous press on ch0 and ch3
        sw_i = 4'h0;
        run(40);
        clear_log();
        sw_i = 4'b1001;
        for (int n = 0; n < 40 && lch.size() < 2; n++) step();
        chk("sim_evcnt", lch.size(), 2);
        if (lch.size() >= 2) begin
            chk("sim_ch0", lch[0], 0);
            chk("sim_ch1", lch[1], 3);
            chk("sim_rise", lr[0] + lr[1], 2);
            chk("sim_gap", lcyc[1] - lcyc[0], 1);
        end
        sw_i = 4'h0;
        run(40);

        // Clean press and release on ch2
        sw_i[2] = 1'b1;
        for (int n = 0; n < 16 && !evt_valid_o; n++) step();
        chk("press_valid", evt_valid_o, 1);
        chk("press_ch", evt_ch_o, 2);
        chk("press_rise", evt_rise_o, 1);
        chk("press_level", level_o[2], 1);
        step();
        sw_i[2] = 1'b0;
        for (int n = 0; n < 16 && !evt_valid_o; n++) step();
        chk("rel_valid", evt_valid_o, 1);
        chk("rel_ch", evt_ch_o, 2);
        chk("rel_rise", evt_rise_o, 0);
        chk("rel_level", level_o[2], 0);
        run(5);

        // Bounce on ch1: runs of 5 cycles never reach 3 equal samples
        clear_log();
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (i % 5 == 0) sw_i[1] = ~sw_i[1];
            step();
            if (level_o[1]) seen = 1;
        end
        sw_i[1] = 1'b0;
        run(30);
        chk("bounce_lvl", seen, 0);
        chk("bounce_ev", lch.size(), 0);

        // Backpressure and overflow on ch1
        evt_ready_i = 1'b0;
        sw_i[1] = 1'b1;
        for (int n = 0; n < 20 && !evt_valid_o; n++) step();
        chk("bp_valid", evt_valid_o, 1);
        run(3);
        chk("bp_hold_v", evt_valid_o, 1);
        chk("bp_hold_ch", evt_ch_o, 1);
        chk("bp_hold_r", evt_rise_o, 1);
        sw_i[1] = 1'b0;
        for (int n = 0; n < 20 && !pend_o[1]; n++) step();
        chk("bp_pend", pend_o[1], 1);
        chk("bp_hold2_ch", evt_ch_o, 1);
        chk("bp_hold2_r", evt_rise_o, 1);
        sw_i[1] = 1'b1;
        for (int n = 0; n < 20 && !ovf_o; n++) step();
        chk("bp_ovf", ovf_o, 1);
        clear_log();
        evt_ready_i = 1'b1;
        run(3);
        chk("bp_evcnt", lch.size(), 2);
        if (lch.size() >= 2) begin
            chk("bp_ev0", {lch[0], lr[0]}, {32'd1, 32'd1});
            chk("bp_ev1", {lch[1], lr[1]}, {32'd1, 32'd1});
        end
        ovf_clr_i = 1'b1;
        step();
        ovf_clr_i = 1'b0;
        chk("ovf_clr", ovf_o, 0);

        // Freeze ch2 mid-debounce, then reset while an event is held
        sw_i[2] = 1'b1;
        for (int n = 0; n < 20 && mrun[2] == 0; n++) step();
        en_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (level_o[2] || pend_o[2]) seen = 1;
        end
        chk("frz_hold", seen, 0);
        en_i = 1'b1;
        evt_ready_i = 1'b0;
        for (int n = 0; n < 30 && !evt_valid_o; n++) step();
        chk("frz_valid", evt_valid_o, 1);
        rst_i = 1'b0;
        model_reset();
        #1;
        chk("arst_valid", evt_valid_o, 0);
        chk("arst_pend", pend_o, 0);
        chk("arst_level", level_o, 0);
        run(3);
        rst_i = 1'b1;
        evt_ready_i = 1'b1;
        clear_log();
        run(6);
        chk("post_rst_ev", lch.size(), 0);
        run(40);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            evt_ready_i = ($urandom_range(0, 3) != 0);
            ovf_clr_i   = ($urandom_range(0, 49) == 0);
            en_i        = ($urandom_range(0, 99) >= 3);
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 24) == 0) sw_i[c] = ~sw_i[c];
            step();
        end
        evt_ready_i = 1'b1; en_i = 1'b1; ovf_clr_i = 1'b0;
        run(50);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
